imm_gen_pipe: RTL and testbench

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

---
 rtl/imm_gen_pipe.sv | 144 ++++++++++++++
 tb/tb_imm_gen_pipe.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator feeding a 2-entry FIFO.
// Entries carry the immediate, a sideband tag and an illegal-format flag.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [2:0]       in_itype,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_Z   = 3'd6,
        FMT_RSV = 3'd7
    } fmt_e;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
        logic             illegal;
    } entry_t;

    fmt_e        fmt;
    logic [31:0] imm32;
    logic        illegal;
    logic [XLEN-1:0] imm_ext;
    logic        unused_opcode;

    assign fmt = fmt_e'(in_itype);
    assign unused_opcode = ^in_inst[6:0];

    // Every 32-bit form already carries its sign in bit 31; Z keeps it 0
    always_comb begin
        imm32   = '0;
        illegal = 1'b0;
        unique case (fmt)
            FMT_I: imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
            FMT_S: imm32 = {{20{in_inst[31]}}, in_inst[31:25],
                            in_inst[11:7]};
            FMT_B: imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                            in_inst[30:25], in_inst[11:8], 1'b0};
            FMT_U: imm32 = {in_inst[31:12], 12'b0};
            FMT_J: imm32 = {{11{in_inst[31]}}, in_inst[31],
                            in_inst[19:12], in_inst[20],
                            in_inst[30:21], 1'b0};
            FMT_Z: imm32 = {27'b0, in_inst[19:15]};
            FMT_RSV: illegal = 1'b1;
            default: imm32 = '0;
        endcase
    end

    generate
        if (XLEN == 64) begin : g_x64
            assign imm_ext = {{32{imm32[31]}}, imm32};
        end else begin : g_x32
            assign imm_ext = imm32[XLEN-1:0];
        end
    endgenerate

    entry_t     mem_q [2];
    logic [1:0] count_q, count_d;
    logic       wptr_q, wptr_d;
    logic       rptr_q, rptr_d;
    logic       push, pop, wr_en;
    entry_t     wr_entry, head;

    assign in_ready  = !rst && (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    assign wr_entry.imm     = imm_ext;
    assign wr_entry.tag     = in_tag;
    assign wr_entry.illegal = illegal;

    always_comb begin
        count_d = count_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        wr_en   = 1'b0;
        if (flush) begin
            count_d = 2'd0;
            wptr_d  = 1'b0;
            rptr_d  = 1'b0;
        end else begin
            if (push) begin
                wr_en  = 1'b1;
                wptr_d = ~wptr_q;
            end
            if (pop) begin
                rptr_d = ~rptr_q;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 2'd0;
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else if (wr_en) begin
            mem_q[wptr_q] <= wr_entry;
        end
    end

    // Empty slots may hold stale data, so mask the head when nothing is valid
    assign head        = out_valid ? mem_q[rptr_q] : '0;
    assign out_imm     = head.imm;
    assign out_tag     = head.tag;
    assign out_illegal = head.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe, XLEN=32 and XLEN=64 side by side.
// Both instances share stimulus; the 64-bit one checks sign extension.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_inst, in_tag;
    logic [2:0]  in_itype;

    logic        rdy32, vld32, ill32;
    logic [31:0] imm32, tag32;
    logic        rdy64, vld64, ill64;
    logic [63:0] imm64;
    logic [31:0] tag64;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy32),
        .in_inst(in_inst), .in_itype(in_itype), .in_tag(in_tag),
        .out_valid(vld32), .out_ready(out_ready),
        .out_imm(imm32), .out_tag(tag32), .out_illegal(ill32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy64),
        .in_inst(in_inst), .in_itype(in_itype), .in_tag(in_tag),
        .out_valid(vld64), .out_ready(out_ready),
        .out_imm(imm64), .out_tag(tag64), .out_illegal(ill64)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [31:0] inst, input logic [2:0] it,
                         input logic [31:0] tg);
        in_valid = 1'b1;
        in_inst  = inst;
        in_itype = it;
        in_tag   = tg;
    endtask

    // One entry in, checked one cycle later, then drained
    task automatic send_one(input string nm, input logic [31:0] inst,
                            input logic [2:0] it, input logic [31:0] tg,
                            input logic [63:0] e32, input logic [63:0] e64,
                            input logic eill);
        out_ready = 1'b1;
        offer(inst, it, tg);
        tick();
        in_valid = 1'b0;
        chk({nm, "_valid"}, 64'(vld32), 64'd1);
        chk({nm, "_imm32"}, 64'(imm32), e32);
        chk({nm, "_imm64"}, imm64, e64);
        chk({nm, "_tag"}, 64'(tag32), 64'(tg));
        chk({nm, "_ill"}, 64'(ill32), 64'(eill));
        tick();
        chk({nm, "_drained"}, 64'(vld32), 64'd0);
        chk({nm, "_zero_imm"}, 64'(imm32), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = '0; in_itype = '0; in_tag = '0;
        tick();
        tick();
        chk("rst_in_ready", 64'(rdy32), 64'd0);
        chk("rst_out_valid", 64'(vld32), 64'd0);
        chk("rst_imm", 64'(imm32), 64'd0);
        chk("rst_tag", 64'(tag32), 64'd0);
        chk("rst_ill", 64'(ill32), 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 64'(rdy32), 64'd1);
        chk("post_rst_ready64", 64'(rdy64), 64'd1);

        // Immediate formats
        send_one("I", 32'hFFF00093, 3'd1, 32'h100,
                 64'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        send_one("S", 32'h00112623, 3'd2, 32'h104,
                 64'h0000000C, 64'h000000000000000C, 1'b0);
        send_one("B", 32'hFE000EE3, 3'd3, 32'h108,
                 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
        send_one("U", 32'h12345037, 3'd4, 32'h10C,
                 64'h12345000, 64'h0000000012345000, 1'b0);
        send_one("Uneg", 32'h80000037, 3'd4, 32'h110,
                 64'h80000000, 64'hFFFFFFFF80000000, 1'b0);
        send_one("J", 32'h800000EF, 3'd5, 32'h114,
                 64'hFFF00000, 64'hFFFFFFFFFFF00000, 1'b0);
        send_one("Z", 32'h0002D073, 3'd6, 32'h118,
                 64'h00000005, 64'h0000000000000005, 1'b0);
        send_one("R", 32'hFFFFFFFF, 3'd0, 32'h11C,
                 64'h0, 64'h0, 1'b0);
        send_one("RSV", 32'hDEADBEEF, 3'd7, 32'h120,
                 64'h0, 64'h0, 1'b1);

        // Backpressure: A, B accepted, C held until space frees up
        out_ready = 1'b0;
        offer(32'h0000A037, 3'd4, 32'hA);
        tick();
        chk("bp_ready_c1", 64'(rdy32), 64'd1);
        offer(32'h0000B037, 3'd4, 32'hB);
        tick();
        offer(32'h0000C037, 3'd4, 32'hC);
        #1;
        chk("bp_full_ready", 64'(rdy32), 64'd0);
        chk("bp_head_a", 64'(tag32), 64'hA);
        tick();
        chk("bp_hold_tag", 64'(tag32), 64'hA);
        chk("bp_hold_imm", 64'(imm32), 64'h0000A000);
        chk("bp_hold_ready", 64'(rdy32), 64'd0);
        out_ready = 1'b1;
        tick();
        chk("bp_head_b", 64'(tag32), 64'hB);
        chk("bp_imm_b", 64'(imm32), 64'h0000B000);
        tick();
        in_valid = 1'b0;
        chk("bp_head_c", 64'(tag32), 64'hC);
        chk("bp_imm_c", 64'(imm32), 64'h0000C000);
        chk("bp_valid_c", 64'(vld32), 64'd1);
        tick();
        chk("bp_no_dup", 64'(vld32), 64'd0);

        // Streaming at occupancy 1
        out_ready = 1'b0;
        offer(32'h00100093, 3'd1, 32'h10);
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            offer(32'h00100093, 3'd1, 32'h11 + i);
            #1;
            chk("stream_tag", 64'(tag32), 64'(32'h10 + i));
            chk("stream_ready", 64'(rdy32), 64'd1);
            tick();
        end
        in_valid = 1'b0;
        chk("stream_last", 64'(tag32), 64'h14);
        chk("stream_imm", 64'(imm32), 64'd1);
        tick();
        chk("stream_empty", 64'(vld32), 64'd0);

        // Flush at count 2, then at count 1 with a live input transfer
        out_ready = 1'b0;
        offer(32'h0, 3'd0, 32'h21);
        tick();
        offer(32'h0, 3'd0, 32'h22);
        tick();
        offer(32'h0, 3'd0, 32'h77);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl2_valid", 64'(vld32), 64'd0);
        chk("fl2_ready", 64'(rdy32), 64'd1);
        chk("fl2_tag", 64'(tag32), 64'd0);
        tick();
        chk("fl2_still_empty", 64'(vld32), 64'd0);
        offer(32'h0, 3'd0, 32'h31);
        tick();
        offer(32'h0, 3'd0, 32'h99);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl1_valid", 64'(vld32), 64'd0);
        tick();
        chk("fl1_no_ghost", 64'(vld32), 64'd0);
        send_one("post_flush", 32'h0002D073, 3'd6, 32'h55,
                 64'h5, 64'h5, 1'b0);

        // Reset with two entries buffered and a handshake pending
        out_ready = 1'b0;
        offer(32'hFFF00093, 3'd7, 32'h41);
        tick();
        offer(32'hFFF00093, 3'd1, 32'h42);
        tick();
        chk("pre_rst_ill", 64'(ill32), 64'd1);
        rst = 1'b1;
        out_ready = 1'b1;
        offer(32'hFFF00093, 3'd1, 32'h43);
        tick();
        chk("mid_rst_valid", 64'(vld32), 64'd0);
        chk("mid_rst_imm", 64'(imm32), 64'd0);
        chk("mid_rst_imm64", imm64, 64'd0);
        chk("mid_rst_tag", 64'(tag32), 64'd0);
        chk("mid_rst_ill", 64'(ill32), 64'd0);
        chk("mid_rst_ready", 64'(rdy32), 64'd0);
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("after_rst_ready", 64'(rdy32), 64'd1);
        tick();
        chk("after_rst_empty", 64'(vld32), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
